cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Precise-exception responder for the five-stage pipeline. It consumes the `ExceptinPipeType` vector carried to MEM by the EXE/MEM register, arbitrates the highest-priority cause, and records it in the CP0 state registers (BadVAddr, Count, Compare, Status, Cause, EPC). In the same cycle it drives the flush and redirect signals back up the pipe, closing the exception loop opened at IF/ID/EXE. It also serves MFC0 reads, commits MTC0 writes, and raises hardware, software and timer interrupts.

## Interface
- `EXC_VECTOR`, `32'hBFC0_0380`: handler entry PC for all exceptions and interrupts.
- `COUNT_DIV`, `2`: core cycles per Count increment; power of two, ≥1.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ext_int`  in  6  hardware interrupt lines, level-sensitive, mapped to Cause.IP[7:2].
- `MEM_Valid`  in  1  MEM holds a real instruction, not a bubble.
- `MEM_ExceptType`  in  9  `ExceptinPipeType`, bit 8 = Interrupt … bit 0 = RdWrongAddressinMEM; the Interrupt bit is ignored here.
- `MEM_PC`  in  32  byte PC of the MEM instruction.
- `MEM_InDelaySlot`  in  1  MEM instruction is in a branch delay slot.
- `MEM_ALUOut`  in  32  effective data address, used for BadVAddr.
- `MEM_CP0Wr`  in  1  MTC0 in MEM (`RegsWrType.CP0Wr`).
- `MEM_Dst`  in  5  CP0 register number for the write.
- `MEM_OutB`  in  32  MTC0 data.
- `cp0_raddr`  in  5  MFC0 read address.
- `cp0_rdata`  out  32  combinational read data; unimplemented registers read 0.
- `exc_taken`  out  1  exception or ERET commits this cycle.
- `exc_target`  out  32  redirect PC: `EXC_VECTOR`, or EPC for ERET.
- `IFID_Flush`, `IDEXE_Flush`, `EXEMEM_Flush`  out  1 each  equal to `exc_taken`.
- `MEM_KillWr`  out  1  suppress RF/HILO/DM writes of the MEM instruction; high for exceptions, low for ERET.
- `int_pending`  out  1  `Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)`.

## Operation
- **Register bits.**
  - Status: BEV[22] read-only 1; IM[15:8], EXL[1] and IE[0] are writable.
  - Cause: BD[31] and TI[30] are read-only; IP[7:2] tracks hardware lines; IP[1:0] is writable; ExcCode[6:2] is read-only.
- **Cause.IP[7:2] source.** Sampled each cycle from `ext_int`, except that with the timer compiled in, IP[7] = `ext_int[5] | TI`.
- **Arbitration.** Active only when `MEM_Valid`. Priority, high to low, with ExcCode:
  - interrupt (`int_pending`): 0
  - WrongAddressinIF: 4
  - ReservedInstruction: 10
  - Overflow: 12
  - Syscall: 8
  - Break: 9
  - RdWrongAddressinMEM: 4
  - WrWrongAddressinMEM: 5
  - Eret is taken only when no other cause is present.
- **On an exception, at the next edge:**
  - If Status.EXL=0: EPC ← `MEM_InDelaySlot ? MEM_PC-4 : MEM_PC`, and Cause.BD ← `MEM_InDelaySlot`.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Status.EXL ← 1 and ExcCode ← code.
  - BadVAddr ← `MEM_PC` for an IF address error, or `MEM_ALUOut` for a data address error.
- **On ERET:** Status.EXL ← 0 at the edge; `exc_target` = current EPC.
- **MTC0 commit.** The write is committed at the edge only if `MEM_CP0Wr & MEM_Valid & ~exc_taken`. Writes to read-only fields are ignored.
- **Collisions.**
  - MTC0 to Count beats the increment.
  - MTC0 to Compare clears TI, and this beats a same-cycle match.
  - MTC0 to Status plus a same-cycle exception cannot occur, because the exception suppresses the MTC0.
- **No MTC0→MFC0 forwarding.** The hazard unit stalls dependent MFC0s.

## Timing
- Detection and redirect are combinational within the MEM cycle: `exc_taken`, the flushes, `exc_target` and `MEM_KillWr` are valid in the same cycle. State updates land at the next rising `clk`.
- The handler's first instruction is fetched the cycle after `exc_taken`.
- While `rst`=0, all outputs are 0 except `cp0_rdata`.
- Reset values:
  - Status = `32'h0040_0000`
  - Cause, EPC, BadVAddr, Count, Compare = 0
  - divider = 0, TI = 0
- Reset deasserted mid-operation leaves no residual state: the next exception starts from EXL=0.
- A level interrupt held across an exception is masked by EXL=1 until ERET.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count increments by 1 every `COUNT_DIV` cycles and wraps `32'hFFFF_FFFF`→0.
  - TI is set on the cycle Count==Compare and held until Compare is written.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0, and writes to them are ignored.
  - TI = 0, and IP[7] = `ext_int[5]`.

## Test plan
- **Syscall, no delay slot.** Syscall at `MEM_PC`=`0xBFC0_0100`, not in a slot, Status=`0x0040_0001` → `exc_taken`=1 in that cycle, `exc_target`=`0xBFC0_0380`. Next cycle: EPC=`0xBFC0_0100`, ExcCode=8, EXL=1, BD=0.
- **Load address error in a delay slot.** RdWrongAddress with `MEM_ALUOut`=`0x8000_0003` and `MEM_InDelaySlot`=1 → EPC=PC-4, BD=1, BadVAddr=`0x8000_0003`, ExcCode=4, `MEM_KillWr`=1.
- **Simultaneous causes.** Overflow and Break asserted together → ExcCode=12. Then Eret with EPC=`0xBFC0_0200` → target `0xBFC0_0200`, EXL=0 next cycle, `MEM_KillWr`=0.
- **Interrupt masking.** `ext_int`=`6'b000001` with Status=`0x0040_0401` → `int_pending`=1, ExcCode=0. The same stimulus with EXL=1 → no exception, and a nested fault leaves EPC unchanged.
- **Timer.** With `CP0_TIMER_EN`, write Compare=5 and Count=0 → TI set after 10 cycles (`COUNT_DIV`=2); writing Compare clears it. Count=`0xFFFF_FFFF` wraps to 0.
- **Suppressed MTC0 and reset.** MTC0 Status in the same cycle as an Overflow → Status IE/IM unchanged. Asserting `rst` low mid-handler → Status=`0x0040_0000` and all flushes 0.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: MEM-stage exception arbitration, redirect/flush and CP0 register file.
// Count/Compare timer and TI are built only when CP0_TIMER_EN is defined.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    input  logic        MEM_Valid,
    input  logic [8:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_InDelaySlot,
    input  logic [31:0] MEM_ALUOut,
    input  logic        MEM_CP0Wr,
    input  logic [4:0]  MEM_Dst,
    input  logic [31:0] MEM_OutB,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        exc_taken,
    output logic [31:0] exc_target,
    output logic        IFID_Flush,
    output logic        IDEXE_Flush,
    output logic        EXEMEM_Flush,
    output logic        MEM_KillWr,
    output logic        int_pending
);
    localparam logic [4:0] R_BADV = 5'd8, R_COUNT = 5'd9, R_CMP = 5'd11;
    localparam logic [4:0] R_STATUS = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;

    logic [31:0] badv_q, badv_d, epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [5:0]  hw_ip_q, hw_ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] count_rd, cmp_rd, status, cause;
    logic [7:0]  ip;
    logic [4:0]  code;
    logic        ti, any_exc, eret, wr, if_err, data_err;
    logic        unused_int;

    assign unused_int = MEM_ExceptType[8];

    assign ip          = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};
    assign status      = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause       = {bd_q, ti, 14'd0, ip, 1'b0, code_q, 2'b00};
    assign int_pending = ie_q & ~exl_q & |(ip & im_q);

    // Bit order: 7 IF addr, 6 RI, 5 Ov, 4 Sys, 3 Bp, 2 Eret, 1 Wr addr, 0 Rd addr.
    assign code = int_pending       ? 5'd0  :
                  MEM_ExceptType[7] ? 5'd4  :
                  MEM_ExceptType[6] ? 5'd10 :
                  MEM_ExceptType[5] ? 5'd12 :
                  MEM_ExceptType[4] ? 5'd8  :
                  MEM_ExceptType[3] ? 5'd9  :
                  MEM_ExceptType[0] ? 5'd4  : 5'd5;

    assign any_exc  = rst & MEM_Valid & (int_pending | |MEM_ExceptType[7:3] | |MEM_ExceptType[1:0]);
    assign eret     = rst & MEM_Valid & MEM_ExceptType[2] & ~any_exc;
    assign if_err   = ~int_pending & MEM_ExceptType[7];
    assign data_err = ~int_pending & ~|MEM_ExceptType[7:3] & |MEM_ExceptType[1:0];
    assign wr       = MEM_CP0Wr & MEM_Valid & ~exc_taken;

    assign exc_taken    = any_exc | eret;
    assign exc_target   = rst ? (eret ? epc_q : EXC_VECTOR) : 32'd0;
    assign IFID_Flush   = exc_taken;
    assign IDEXE_Flush  = exc_taken;
    assign EXEMEM_Flush = exc_taken;
    assign MEM_KillWr   = any_exc;

    assign cp0_rdata = cp0_raddr == R_BADV   ? badv_q   :
                       cp0_raddr == R_COUNT  ? count_rd :
                       cp0_raddr == R_CMP    ? cmp_rd   :
                       cp0_raddr == R_STATUS ? status   :
                       cp0_raddr == R_CAUSE  ? cause    :
                       cp0_raddr == R_EPC    ? epc_q    : 32'd0;

    always_comb begin
        badv_d  = badv_q;
        epc_d   = epc_q;
        im_d    = im_q;
        exl_d   = exl_q;
        ie_d    = ie_q;
        bd_d    = bd_q;
        sw_ip_d = sw_ip_q;
        code_d  = code_q;
        hw_ip_d = ext_int;
        if (wr && MEM_Dst == R_STATUS) begin
            im_d  = MEM_OutB[15:8];
            exl_d = MEM_OutB[1];
            ie_d  = MEM_OutB[0];
        end
        if (wr && MEM_Dst == R_CAUSE) sw_ip_d = MEM_OutB[9:8];
        if (wr && MEM_Dst == R_EPC) epc_d = MEM_OutB;
        // A nested exception keeps the EPC/BD of the outermost one.
        if (any_exc) begin
            exl_d  = 1'b1;
            code_d = code;
            if (!exl_q) begin
                epc_d = MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                bd_d  = MEM_InDelaySlot;
            end
            if (if_err) badv_d = MEM_PC;
            else if (data_err) badv_d = MEM_ALUOut;
        end
        if (eret) exl_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badv_q  <= '0;
            epc_q   <= '0;
            im_q    <= '0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            bd_q    <= 1'b0;
            sw_ip_q <= '0;
            hw_ip_q <= '0;
            code_q  <= '0;
        end else begin
            badv_q  <= badv_d;
            epc_q   <= epc_d;
            im_q    <= im_d;
            exl_q   <= exl_d;
            ie_q    <= ie_d;
            bd_q    <= bd_d;
            sw_ip_q <= sw_ip_d;
            hw_ip_q <= hw_ip_d;
            code_q  <= code_d;
        end
    end

`ifdef CP0_TIMER_EN
    localparam int DW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;

    logic [31:0]   count_q, count_d, cmp_q, cmp_d;
    logic [DW-1:0] div_q, div_d;
    logic          ti_q, ti_d, tick;

    assign tick     = div_q == DW'(COUNT_DIV - 1);
    assign count_rd = count_q;
    assign cmp_rd   = cmp_q;
    assign ti       = ti_q;

    // Software writes win over the increment and over a same-cycle compare match.
    always_comb begin
        div_d   = tick ? '0 : div_q + DW'(1);
        count_d = (wr && MEM_Dst == R_COUNT) ? MEM_OutB : count_q + 32'(tick);
        cmp_d   = (wr && MEM_Dst == R_CMP) ? MEM_OutB : cmp_q;
        ti_d    = (wr && MEM_Dst == R_CMP) ? 1'b0 : ti_q | (count_q == cmp_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            cmp_q   <= '0;
            div_q   <= '0;
            ti_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            div_q   <= div_d;
            ti_q    <= ti_d;
        end
    end
`else
    localparam int unused_div = COUNT_DIV;

    assign count_rd = 32'd0;
    assign cmp_rd   = 32'd0;
    assign ti       = 1'b0;
`endif
endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb_cp0_exception_unit: vector table, directed corner sequences and random traffic
// checked against an architectural CP0 model.
module tb_cp0_exception_unit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic [5:0]  ext_int = '0;
    logic        MEM_Valid = 1'b0, MEM_InDelaySlot = 1'b0, MEM_CP0Wr = 1'b0;
    logic [8:0]  MEM_ExceptType = '0;
    logic [31:0] MEM_PC = '0, MEM_ALUOut = '0, MEM_OutB = '0;
    logic [4:0]  MEM_Dst = '0, cp0_raddr = '0;
    logic [31:0] cp0_rdata, exc_target;
    logic        exc_taken, IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEM_KillWr, int_pending;

    always #10 clk = ~clk;

    cp0_exception_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .MEM_Valid(MEM_Valid),
        .MEM_ExceptType(MEM_ExceptType), .MEM_PC(MEM_PC), .MEM_InDelaySlot(MEM_InDelaySlot),
        .MEM_ALUOut(MEM_ALUOut), .MEM_CP0Wr(MEM_CP0Wr), .MEM_Dst(MEM_Dst), .MEM_OutB(MEM_OutB),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .exc_taken(exc_taken),
        .exc_target(exc_target), .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush),
        .EXEMEM_Flush(EXEMEM_Flush), .MEM_KillWr(MEM_KillWr), .int_pending(int_pending)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: registers held as plain words and fields.
    logic [31:0] m_status, m_epc, m_badv, m_count, m_cmp;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    logic        m_bd, m_ti;
    int          m_div;
    int          prio_bit[7]  = '{7, 6, 5, 4, 3, 0, 1};
    int          prio_code[7] = '{4, 10, 12, 8, 9, 4, 5};

    task automatic m_reset();
        m_status = 32'h0040_0000;
        {m_epc, m_badv, m_count, m_cmp} = '0;
        m_code = '0; m_sw = '0; m_hw = '0; m_bd = 1'b0; m_ti = 1'b0; m_div = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic m_pend();
        return m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_eval(output logic exc, output logic er, output logic [4:0] code, output int src);
        exc = 1'b0; er = 1'b0; code = '0; src = -1;
        if (MEM_Valid) begin
            if (m_pend()) exc = 1'b1;
            else begin
                for (int i = 0; i < 7; i++)
                    if (!exc && MEM_ExceptType[prio_bit[i]]) begin
                        exc = 1'b1; code = 5'(prio_code[i]); src = prio_bit[i];
                    end
                er = ~exc & MEM_ExceptType[2];
            end
        end
    endtask

    task automatic m_update();
        logic exc, er, hit;
        logic [4:0] code;
        int src;
        m_eval(exc, er, code, src);
        hit = m_count == m_cmp;
`ifdef CP0_TIMER_EN
        m_ti = m_ti | hit;
        if (m_div == DIV - 1) m_count = m_count + 1;
        m_div = (m_div + 1) % DIV;
`endif
        m_hw = ext_int;
        if (exc) begin
            if (!m_status[1]) begin
                m_epc = MEM_InDelaySlot ? MEM_PC - 4 : MEM_PC;
                m_bd = MEM_InDelaySlot;
            end
            m_status[1] = 1'b1;
            m_code = code;
            if (src == 7) m_badv = MEM_PC;
            else if (src == 0 || src == 1) m_badv = MEM_ALUOut;
        end
        if (er) m_status[1] = 1'b0;
        if (MEM_CP0Wr && MEM_Valid && !exc && !er)
            case (MEM_Dst)
`ifdef CP0_TIMER_EN
                5'd9:  m_count = MEM_OutB;
                5'd11: begin m_cmp = MEM_OutB; m_ti = 1'b0; end
`endif
                5'd12: m_status = (m_status & ~32'h0000_FF03) | (MEM_OutB & 32'h0000_FF03);
                5'd13: m_sw = MEM_OutB[9:8];
                5'd14: m_epc = MEM_OutB;
                default: ;
            endcase
    endtask

    logic        l_taken, l_kill, l_pend;
    logic [31:0] l_target;

    // One clock: compare combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic exc, er;
        logic [4:0] code;
        int src;
        @(negedge clk); #1;
        m_eval(exc, er, code, src);
        l_taken = exc_taken; l_kill = MEM_KillWr; l_pend = int_pending; l_target = exc_target;
        chk("int_pending", 32'(int_pending), 32'(m_pend()));
        chk("exc_taken", 32'(exc_taken), 32'(exc | er));
        chk("flushes", 32'({IFID_Flush, IDEXE_Flush, EXEMEM_Flush}), 32'({3{exc | er}}));
        chk("kill_wr", 32'(MEM_KillWr), 32'(exc));
        if (exc || er) chk("exc_target", exc_target, er ? m_epc : VEC);
        chk("cp0_rdata", cp0_rdata, m_read(cp0_raddr));
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] mask, input logic [31:0] exp);
        cp0_raddr = a; #1;
        chk(name, cp0_rdata & mask, exp & mask);
    endtask

    task automatic idle();
        MEM_Valid = 1'b0; MEM_ExceptType = '0; MEM_CP0Wr = 1'b0; MEM_InDelaySlot = 1'b0;
    endtask

    task automatic set_mem(input logic v, input logic [8:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] alu);
        MEM_Valid = v; MEM_ExceptType = t; MEM_PC = pc; MEM_InDelaySlot = ds; MEM_ALUOut = alu; MEM_CP0Wr = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] dst, input logic [31:0] d);
        set_mem(1'b1, 9'd0, 32'h8000_0000, 1'b0, 32'd0);
        MEM_CP0Wr = 1'b1; MEM_Dst = dst; MEM_OutB = d;
        cycle();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b0; m_reset(); #1;
        chk("reset_outs", 32'({exc_taken, IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEM_KillWr, int_pending}), 32'd0);
        chk("reset_target", exc_target, 32'd0);
        rd("reset_status", 5'd12, '1, 32'h0040_0000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] st;
        logic [5:0]  ei;
        logic        v;
        logic [8:0]  t;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] alu;
        logic        tk;
        logic        kill;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
    } vec_t;

    vec_t        tbl[12];
    logic [4:0]  dsts[6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    logic        got;

    initial begin
        tbl[0]  = '{"syscall",     32'h0040_0001, 6'd0, 1'b1, 9'h010, 32'hBFC0_0100, 1'b0, 32'h0,         1'b1, 1'b1, 5'd8,  32'hBFC0_0100, 1'b0, 32'h0};
        tbl[1]  = '{"load_adel",   32'h0040_0000, 6'd0, 1'b1, 9'h001, 32'hBFC0_0204, 1'b1, 32'h8000_0003, 1'b1, 1'b1, 5'd4,  32'hBFC0_0200, 1'b1, 32'h8000_0003};
        tbl[2]  = '{"ov_and_brk",  32'h0040_0000, 6'd0, 1'b1, 9'h028, 32'h8000_1000, 1'b0, 32'h5,         1'b1, 1'b1, 5'd12, 32'h8000_1000, 1'b0, 32'h0};
        tbl[3]  = '{"interrupt",   32'h0040_0401, 6'd1, 1'b1, 9'h000, 32'h8000_0040, 1'b0, 32'h0,         1'b1, 1'b1, 5'd0,  32'h8000_0040, 1'b0, 32'h0};
        tbl[4]  = '{"if_adel",     32'h0040_0000, 6'd0, 1'b1, 9'h080, 32'h8000_0001, 1'b0, 32'h7,         1'b1, 1'b1, 5'd4,  32'h8000_0001, 1'b0, 32'h8000_0001};
        tbl[5]  = '{"ri_over_sys", 32'h0040_0000, 6'd0, 1'b1, 9'h050, 32'h8000_0010, 1'b0, 32'h0,         1'b1, 1'b1, 5'd10, 32'h8000_0010, 1'b0, 32'h0};
        tbl[6]  = '{"store_ades",  32'h0040_0000, 6'd0, 1'b1, 9'h002, 32'h8000_0020, 1'b1, 32'h10,        1'b1, 1'b1, 5'd5,  32'h8000_001C, 1'b1, 32'h10};
        tbl[7]  = '{"rd_over_wr",  32'h0040_0000, 6'd0, 1'b1, 9'h003, 32'h8000_0030, 1'b0, 32'h22,        1'b1, 1'b1, 5'd4,  32'h8000_0030, 1'b0, 32'h22};
        tbl[8]  = '{"int_over_if", 32'h0040_0401, 6'd1, 1'b1, 9'h080, 32'h8000_0050, 1'b0, 32'h9,         1'b1, 1'b1, 5'd0,  32'h8000_0050, 1'b0, 32'h0};
        tbl[9]  = '{"bubble",      32'h0040_0001, 6'd0, 1'b0, 9'h010, 32'h8000_0060, 1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
        tbl[10] = '{"im_masked",   32'h0040_0801, 6'd1, 1'b1, 9'h000, 32'h8000_0068, 1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
        tbl[11] = '{"eret_and_sys",32'h0040_0000, 6'd0, 1'b1, 9'h014, 32'h8000_0070, 1'b0, 32'h0,         1'b1, 1'b1, 5'd8,  32'h8000_0070, 1'b0, 32'h0};

        m_reset();
        foreach (tbl[k]) begin
            ext_int = '0; idle();
            do_reset();
            if (tbl[k].st != 32'h0040_0000) mtc0(5'd12, tbl[k].st);
            ext_int = tbl[k].ei;
            cycle();
            set_mem(tbl[k].v, tbl[k].t, tbl[k].pc, tbl[k].ds, tbl[k].alu);
            cycle();
            chk({tbl[k].name, "_taken"}, 32'(l_taken), 32'(tbl[k].tk));
            chk({tbl[k].name, "_kill"}, 32'(l_kill), 32'(tbl[k].kill));
            if (tbl[k].tk) chk({tbl[k].name, "_target"}, l_target, VEC);
            idle();
            rd({tbl[k].name, "_epc"}, 5'd14, '1, tbl[k].epc);
            rd({tbl[k].name, "_cause"}, 5'd13, 32'h8000_007C, (32'(tbl[k].bd) << 31) | (32'(tbl[k].code) << 2));
            rd({tbl[k].name, "_badv"}, 5'd8, '1, tbl[k].badv);
            rd({tbl[k].name, "_status"}, 5'd12, '1, tbl[k].st | (32'(tbl[k].tk) << 1));
        end

        // Overflow+Break, then ERET back to a software-set EPC.
        ext_int = '0; do_reset();
        mtc0(5'd12, 32'h0000_0001);
        set_mem(1'b1, 9'h028, 32'h8000_0200, 1'b0, 32'h0); cycle(); idle();
        mtc0(5'd14, 32'hBFC0_0200);
        set_mem(1'b1, 9'h004, 32'h8000_0300, 1'b0, 32'h0); cycle();
        chk("eret_taken", 32'(l_taken), 32'd1);
        chk("eret_target", l_target, 32'hBFC0_0200);
        chk("eret_kill", 32'(l_kill), 32'd0);
        idle();
        rd("eret_exl", 5'd12, 32'h2, 32'h0);

        // Level interrupt masked by EXL; a nested fault keeps EPC.
        do_reset();
        ext_int = 6'b000001;
        mtc0(5'd14, 32'h1234_5678);
        mtc0(5'd12, 32'h0000_0403);
        set_mem(1'b1, 9'h000, 32'h8000_0400, 1'b0, 32'h0); cycle();
        chk("exl_mask_pend", 32'(l_pend), 32'd0);
        chk("exl_mask_taken", 32'(l_taken), 32'd0);
        set_mem(1'b1, 9'h010, 32'h8000_0404, 1'b1, 32'h0); cycle(); idle();
        chk("nested_taken", 32'(l_taken), 32'd1);
        rd("nested_epc", 5'd14, '1, 32'h1234_5678);
        rd("nested_code", 5'd13, 32'h7C, 32'd8 << 2);

        // MTC0 Status suppressed by a same-cycle overflow.
        ext_int = '0; do_reset();
        mtc0(5'd12, 32'h0000_0401);
        set_mem(1'b1, 9'h020, 32'h8000_0500, 1'b0, 32'h0);
        MEM_CP0Wr = 1'b1; MEM_Dst = 5'd12; MEM_OutB = 32'h0000_FF00;
        cycle(); idle();
        rd("suppressed_status", 5'd12, '1, 32'h0040_0403);

        // Reset mid-handler with a live syscall on the inputs, then EXL starts clean.
        set_mem(1'b1, 9'h010, 32'h8000_0600, 1'b0, 32'h0);
        do_reset();
        rd("rst_epc", 5'd14, '1, 32'h0);
        set_mem(1'b1, 9'h010, 32'h8000_0100, 1'b1, 32'h0); cycle(); idle();
        rd("post_rst_epc", 5'd14, '1, 32'h8000_00FC);
        rd("post_rst_bd", 5'd13, 32'h8000_0000, 32'h8000_0000);

`ifdef CP0_TIMER_EN
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        cp0_raddr = 5'd13;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            cycle();
            cp0_raddr = 5'd13; #1;
            got = cp0_rdata[30];
        end
        chk("ti_set", 32'(got), 32'd1);
        mtc0(5'd11, 32'd100);
        rd("ti_clear", 5'd13, 32'h4000_0000, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd("count_write", 5'd9, '1, 32'hFFFF_FFFF);
        for (int c = 0; c < DIV; c++) cycle();
        rd("count_wrap", 5'd9, '1, 32'h0);
`else
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd7);
        rd("no_timer_count", 5'd9, '1, 32'h0);
        rd("no_timer_cmp", 5'd11, '1, 32'h0);
        rd("no_timer_ti", 5'd13, 32'h4000_0000, 32'h0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int r;
            r = int'($urandom_range(7));
            MEM_Valid = $urandom_range(3) != 0;
            MEM_ExceptType = r == 0 ? 9'($urandom) : r == 1 ? 9'(1 << $urandom_range(8)) : 9'd0;
            MEM_PC = $urandom & 32'hFFFF_FFFC;
            MEM_InDelaySlot = 1'($urandom_range(1));
            MEM_ALUOut = $urandom;
            MEM_CP0Wr = $urandom_range(2) == 0;
            MEM_Dst = dsts[$urandom_range(5)];
            MEM_OutB = $urandom;
            if ($urandom_range(15) == 0) ext_int = 6'($urandom);
            cp0_raddr = 5'($urandom);
            if (n == 400) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
